// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file write port between pipeline writeback (always wins)
// and a FIFO-buffered secondary writer. Optional same-cycle bypass: `define RF_ARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        pending_hit,
    output logic        stall_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW-1:0]   occupancy;
    logic [3:0]      starve_cnt, starve_nxt;
    logic            stall_nxt;
    logic            empty, full;
    logic            wb_take, slot_free;
    logic            push, pop, bypass_fire;
    logic [DEPTH-1:0] entry_valid;
    entry_t          head;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign occupancy = wr_ptr - rd_ptr;
    assign aux_ready = !full;
    assign head      = mem[rd_ptr[AW-1:0]];

    // Writes to r0 are architectural no-ops, so they leave the slot available.
    assign wb_take   = wb_we && (wb_addr != 5'd0);
    assign slot_free = !wb_take;
    assign pop       = slot_free && !empty;

`ifdef RF_ARB_BYPASS_EN
    assign bypass_fire = empty && slot_free && aux_valid && (aux_addr != 5'd0);
`else
    assign bypass_fire = 1'b0;
`endif

    assign push = aux_valid && aux_ready && (aux_addr != 5'd0) && !bypass_fire;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        rf_we   = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (wb_take) begin
            rf_we   = 1'b1;
            rf_addr = wb_addr;
            rf_data = wb_data;
        end else if (!empty) begin
            rf_we   = 1'b1;
            rf_addr = head.addr;
            rf_data = head.data;
        end else if (bypass_fire) begin
            rf_we   = 1'b1;
            rf_addr = aux_addr;
            rf_data = aux_data;
        end
    end

    // An entry is live when its distance from the read index is below the occupancy.
    always_comb begin
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] offset;
            offset         = AW'(i) - rd_ptr[AW-1:0];
            entry_valid[i] = ({1'b0, offset} < occupancy);
        end
    end

    always_comb begin
        pending_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) begin
                if (q_addr1 != 5'd0 && mem[i].addr == q_addr1) pending_hit = 1'b1;
                if (q_addr2 != 5'd0 && mem[i].addr == q_addr2) pending_hit = 1'b1;
            end
        end
        if (bypass_fire) begin
            if (q_addr1 != 5'd0 && aux_addr == q_addr1) pending_hit = 1'b1;
            if (q_addr2 != 5'd0 && aux_addr == q_addr2) pending_hit = 1'b1;
        end
    end

    // Counter saturates at the limit; stall holds until the waiting head finally pops.
    always_comb begin
        starve_nxt = starve_cnt;
        stall_nxt  = stall_req;
        if (empty || pop) begin
            starve_nxt = 4'd0;
            stall_nxt  = 1'b0;
        end else begin
            if (starve_cnt < LIMIT) starve_nxt = starve_cnt + 4'd1;
            if (starve_cnt >= LIMIT) stall_nxt = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= 4'd0;
            stall_req  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            starve_cnt <= starve_nxt;
            stall_req  <= stall_nxt;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{addr: aux_addr, data: aux_data};
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and one secondary multi-cycle writer, such as the multiply/divide unit or a load-return path. Writeback always wins the port. Secondary writes are held in a small FIFO and drain into idle write slots. A starvation counter asks the hazard unit for a bubble when the FIFO head waits too long, and a pending-register check lets decode stall on RAW/WAW hazards against queued writes. The block sits between WB, the secondary unit and the register file write port.

## Interface
Parameters:
- DEPTH, 2: secondary FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 4: cycles the FIFO head may wait before `stall_req` is raised; 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wb_we  in  1  pipeline writeback enable; has no backpressure.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- aux_valid  in  1  secondary write request.
- aux_ready  out  1  FIFO can accept a request; equals !full.
- aux_addr  in  5  secondary destination register.
- aux_data  in  32  secondary data.
- rf_we  out  1  register file write enable.
- rf_addr  out  5  register file write address.
- rf_data  out  32  register file write data.
- q_addr1  in  5  decode source/destination query 1.
- q_addr2  in  5  decode source/destination query 2.
- pending_hit  out  1  a query address matches a valid FIFO entry.
- stall_req  out  1  registered request to the hazard unit to inject a WB bubble.

## Operation
- **Slot free:** the write slot is free when `wb_we==0` or `wb_addr==0`.
- **Port mux:**
  - `wb_we && wb_addr!=0` → rf_* = wb_*.
  - Otherwise, if the FIFO is non-empty → rf_* = FIFO head with `rf_we=1`, and the head pops at the edge.
  - Otherwise `rf_we=0`.
- **Enqueue:** `aux_valid && aux_ready` with `aux_addr!=0` → push at the edge.
  - With `aux_addr==0`, the request is handshaken and discarded, with no push.
- **Simultaneous events:** push and pop in the same cycle is allowed; occupancy is unchanged. `aux_ready` depends only on `full`; there is no pass-through when full.
- **Starvation counter:** 4-bit, counts cycles with the head valid and not popped.
  - It clears on a pop or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, `stall_req` is set at the next edge and holds until the head pops. It clears at the edge of that pop.
- **Pending check:** `pending_hit = OR over valid entries (entry.addr==q_addrN, for N=1,2)`, combinational. A query address of 0 never hits.
  - Decode must stall on a hit. Because of this, WB never writes a register that is pending in the FIFO.
- **Pointers:** log2(DEPTH)+1 bits; empty/full are distinguished by the MSB. Wrap-around is modulo DEPTH.
- **Reset:** asynchronous, active-low.
  - Reset state: FIFO empty, pointers 0, counter 0, `stall_req=0`, `aux_ready=1`, `pending_hit=0`.
  - `rf_we` follows `wb_we` combinationally, with `wb_addr!=0`.
  - Reset mid-operation drops all queued entries; they are never written.

## Timing
- WB path: zero latency (combinational to rf_*). The register file samples it at the same edge.
- Secondary path, minimum latency: accepted at edge N, written to the register file at edge N+1 if that slot is free.
- `stall_req` asserts STARVE_LIMIT+1 edges after the head becomes valid, given continuous WB writes.
- `pending_hit` is valid in the same cycle as the query. Entries push and pop only at clock edges.

## Configuration
- `RF_ARB_BYPASS_EN` defined:
  - When the FIFO is empty, the slot is free and `aux_valid && aux_addr!=0`, the request drives rf_* in the same cycle.
  - The request is handshaken with no push, giving zero latency.
  - `pending_hit` also matches `aux_addr` in that cycle.
- `RF_ARB_BYPASS_EN` undefined: every secondary write goes through the FIFO, so minimum latency is one cycle.

## Test plan
- **Reset then idle:** deassert reset_n → aux_ready=1, rf_we=0, stall_req=0, pending_hit=0.
- **Single secondary write:** with WB idle, push (r5, 0xDEADBEEF).
  - Without the bypass macro: rf_we=1, rf_addr=5 for one cycle after acceptance.
  - With the macro: the write occurs in the same cycle.
- **Writeback priority:** WB writes r3 continuously while two aux entries are queued.
  - aux_ready=0 once full.
  - stall_req rises after 5 edges with STARVE_LIMIT=4.
  - Drop wb_we → both entries drain on consecutive cycles, in FIFO order.
- **r0 handling:** WB write with wb_addr=0 alongside a queued r7 → r7 drains that cycle. An aux request to r0 is accepted, with no push and no rf write.
- **Pending check:** queue r9; q_addr1=9 → pending_hit=1. After the drain edge → pending_hit=0. q_addr2=0 → pending_hit=0.
- **Reset mid-operation:** assert reset_n low with two entries queued → the FIFO empties immediately, no rf write of the queued data, and stall_req=0.
